// File: rtl/gerador_pwm_posicao_if.sv
// Sweep position bus: an update strobe plus the position index it qualifies.
// The scan counter drives it as master; the PWM generator listens as slave.
interface gerador_pwm_posicao_if #(
  parameter int N = 6
);
  logic         atualiza;
  logic [N-1:0] posicao;

  modport master (output atualiza, output posicao);
  modport slave  (input  atualiza, input  posicao);
endinterface

// File: rtl/gerador_pwm_posicao.sv
// Servo PWM driven by the sweep position bus. The pulse width is linear in position.
// A new position takes effect only at a period boundary, so a pulse is never cut short.
module gerador_pwm_posicao #(
  parameter int M           = 50,
  parameter int N           = 6,
  parameter int PERIODO     = 1_000_000,
  parameter int LARGURA_MIN = 50_000,
  parameter int PASSO       = 1_000
) (
  input  logic                 clock,
  input  logic                 zera_as_n,
  input  logic                 zera_s,
  input  logic                 habilita,
  gerador_pwm_posicao_if.slave barramento,
  output logic                 pwm,
  output logic                 inicio_periodo,
  output logic [N-1:0]         posicao_ativa,
  output logic                 erro_posicao
);
  localparam int             W        = $clog2(PERIODO);
  localparam logic [W-1:0]   C_ULTIMO = W'(PERIODO - 1);
  localparam logic [N-1:0]   POS_MAX  = N'(M - 1);

  logic [W-1:0] contador;
  logic [W-1:0] contador_prox;
  logic [W-1:0] largura_ativa;
  logic [W-1:0] largura_nova;
  logic [W-1:0] largura_usada;
  logic [N-1:0] pendente;
  logic [N-1:0] pos_limitada;
  logic [N-1:0] pos_carga;
  logic         fora_faixa;
  logic         vira;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    vira          = (contador == C_ULTIMO);
    contador_prox = vira ? '0 : contador + 1'b1;
    fora_faixa    = (int'(barramento.posicao) >= M);
    pos_limitada  = fora_faixa ? POS_MAX : barramento.posicao;
    // A strobe on the wrap edge itself bypasses the pending register.
    pos_carga     = barramento.atualiza ? pos_limitada : pendente;
    largura_nova  = habilita ? W'(LARGURA_MIN) + W'(pos_carga) * W'(PASSO) : '0;
    largura_usada = vira ? largura_nova : largura_ativa;
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      contador       <= C_ULTIMO;
      pendente       <= '0;
      posicao_ativa  <= '0;
      largura_ativa  <= '0;
      pwm            <= 1'b0;
      inicio_periodo <= 1'b0;
      erro_posicao   <= 1'b0;
    end else if (zera_s) begin
      contador       <= C_ULTIMO;
      pendente       <= '0;
      posicao_ativa  <= '0;
      largura_ativa  <= '0;
      pwm            <= 1'b0;
      inicio_periodo <= 1'b0;
      erro_posicao   <= 1'b0;
    end else begin
      contador       <= contador_prox;
      inicio_periodo <= vira;
      pwm            <= (contador_prox < largura_usada);
      if (barramento.atualiza) begin
        pendente <= pos_limitada;
        if (fora_faixa) erro_posicao <= 1'b1;
      end
      if (vira) begin
        posicao_ativa <= pos_carga;
        largura_ativa <= largura_nova;
      end
    end
  end
endmodule

// File: tb/tb_gerador_pwm_posicao.sv
// Bench for gerador_pwm_posicao: directed sweep-bus stimulus with a per-period scoreboard,
// plus a second instance built with M=6 to exercise clamping and the sticky error flag.
`timescale 1ns/1ps
module tb_gerador_pwm_posicao;
  localparam int M = 8, N = 3, PERIODO = 20, LARGURA_MIN = 4, PASSO = 1;

  logic         clock = 1'b0;
  logic         zera_as_n, zera_s, habilita;
  logic         pwm, inicio_periodo, erro_posicao;
  logic [N-1:0] posicao_ativa;
  logic         pwm6, inicio6, erro6;
  logic [N-1:0] posicao_ativa6;

  always #5 clock = ~clock;

  gerador_pwm_posicao_if #(.N(N)) barramento ();

  gerador_pwm_posicao #(.M(M), .N(N), .PERIODO(PERIODO), .LARGURA_MIN(LARGURA_MIN), .PASSO(PASSO)) dut (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .habilita(habilita),
    .barramento(barramento), .pwm(pwm), .inicio_periodo(inicio_periodo),
    .posicao_ativa(posicao_ativa), .erro_posicao(erro_posicao));

  gerador_pwm_posicao #(.M(6), .N(N), .PERIODO(PERIODO), .LARGURA_MIN(LARGURA_MIN), .PASSO(PASSO)) dut6 (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .habilita(habilita),
    .barramento(barramento), .pwm(pwm6), .inicio_periodo(inicio6),
    .posicao_ativa(posicao_ativa6), .erro_posicao(erro6));

  typedef struct {
    int pos;
    int larg;
    int erro;
  } esperado_t;

  esperado_t fila[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nome, input logic [31:0] lido, input logic [31:0] req);
    n_chk++;
    if (lido !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nome, lido, req);
    end
  endtask

  // Monitor: one scoreboard entry per complete period, opened by inicio_periodo.
  logic      ativo = 1'b0;
  int        amostras, largura;
  logic      forma_ok;
  int        pos_lida, erro_lido;
  esperado_t exp_atual;

  always @(negedge clock) begin
    if (!zera_as_n || zera_s) begin
      ativo = 1'b0;
    end else begin
      if (inicio_periodo) begin
        if (ativo) check("periodo curto", amostras, PERIODO);
        ativo     = 1'b1;
        amostras  = 0;
        largura   = 0;
        forma_ok  = 1'b1;
        pos_lida  = int'(posicao_ativa);
        erro_lido = int'(erro_posicao);
      end
      if (ativo) begin
        if (pwm) begin
          if (largura != amostras) forma_ok = 1'b0;
          largura++;
        end
        amostras++;
        if (amostras == PERIODO) begin
          ativo = 1'b0;
          if (fila.size() == 0) begin
            check("fila vazia no pop", fila.size(), 1);
          end else begin
            exp_atual = fila.pop_front();
            check("posicao_ativa", pos_lida, exp_atual.pos);
            check("largura pwm", largura, exp_atual.larg);
            check("pwm contiguo desde inicio", forma_ok, 1);
            check("erro_posicao", erro_lido, exp_atual.erro);
          end
        end
      end
    end
  end

  task automatic ciclos(input int k);
    repeat (k) @(negedge clock);
    #1;
  endtask

  task automatic strobe(input int p);
    barramento.atualiza = 1'b1;
    barramento.posicao  = N'(p);
    @(negedge clock);
    #1;
    barramento.atualiza = 1'b0;
  endtask

  task automatic wait_inicio();
    bit achou = 1'b0;
    for (int i = 0; i < 2 * PERIODO + 2; i++) begin
      @(negedge clock);
      if (inicio_periodo) begin
        achou = 1'b1;
        break;
      end
    end
    if (!achou) check("timeout inicio_periodo", 0, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " pwm"}, pwm, 0);
    check({tag, " inicio"}, inicio_periodo, 0);
    check({tag, " posicao_ativa"}, posicao_ativa, 0);
    check({tag, " erro"}, erro_posicao, 0);
    check({tag, " erro m6"}, erro6, 0);
  endtask

  int larg6;

  initial begin
    zera_as_n = 1'b1;
    zera_s    = 1'b0;
    habilita  = 1'b1;
    barramento.atualiza = 1'b0;
    barramento.posicao  = '0;
    #2 zera_as_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset("reset");
    #1 zera_as_n = 1'b1;

    // First period starts one cycle after release, position 0 -> width 4.
    @(negedge clock);
    check("inicio no ciclo 1", inicio_periodo, 1);
    fila.push_back('{0, 4, 0});

    // Mid-period strobe leaves this period alone and applies to the next.
    wait_inicio();
    fila.push_back('{0, 4, 0});
    ciclos(10);
    strobe(5);

    // Two strobes in one period, the last one on the wrap edge (bypass).
    wait_inicio();
    fila.push_back('{5, 9, 0});
    ciclos(5);
    strobe(2);
    ciclos(13);
    strobe(7);

    // Now on the first cycle of the bypass period.
    check("inicio apos bypass", inicio_periodo, 1);
    fila.push_back('{7, 11, 0});
    check("erro m6 apos posicao 7", erro6, 1);
    check("posicao_ativa m6 limitada", posicao_ativa6, 5);
    larg6 = int'(pwm6);
    for (int i = 1; i < PERIODO; i++) begin
      @(negedge clock);
      larg6 += int'(pwm6);
      if (i == 2) begin
        #1;
        habilita = 1'b0;
      end
    end
    check("largura m6 limitada", larg6, 9);

    // Disabled period: no pulse but inicio_periodo still arrives.
    wait_inicio();
    fila.push_back('{7, 0, 0});
    ciclos(10);
    habilita = 1'b1;
    check("erro m6 persistente", erro6, 1);

    // Synchronous clear mid-period.
    wait_inicio();
    ciclos(3);
    zera_s = 1'b1;
    @(negedge clock);
    #1 zera_s = 1'b0;
    check_reset("zera_s");
    check("zera_s posicao_ativa m6", posicao_ativa6, 0);

    // Asynchronous reset while the pulse is high.
    wait_inicio();
    ciclos(3);
    check("pwm alto antes do reset", pwm, 1);
    zera_as_n = 1'b0;
    #1 check("pwm cai no reset assincrono", pwm, 0);
    repeat (2) @(negedge clock);
    check_reset("reset assincrono");
    #1 zera_as_n = 1'b1;
    @(negedge clock);
    check("inicio apos reset", inicio_periodo, 1);
    check("pwm no recomeco", pwm, 1);
    fila.push_back('{0, 4, 0});

    wait_inicio();
    fila.push_back('{0, 4, 0});
    ciclos(PERIODO + 1);
    check("fila consumida", fila.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
